// File: rtl/psdsqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psdsqrt_pkg
// Description : Shared definitions for the psdsqrt sequencing controller and
//               the psdsqrt datapath bench: default operand geometry, the
//               controller state encoding and the cycle-budget helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package psdsqrt_pkg;

    // Default operand width and extra-iteration count of the psdsqrt unit.
    localparam int DEFAULT_NBITSIN = 32;
    localparam int DEFAULT_K       = 8;

    // Controller states, explicitly encoded on 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Number of wait cycles psdsqrt needs between start and stop.
    function automatic int ncycles(input int nbitsin, input int k);
        return (nbitsin + k) / 2;
    endfunction

    // Width of a counter that must hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psdsqrt_cyc_counter.sv
`default_nettype none
// ============================================================================
// Module      : psdsqrt_cyc_counter
// Description : Loadable down-counter with a zero flag. A load takes priority
//               over a decrement; the count saturates at zero.
// Ports       : clock    - rising-edge clock
//               reset_n  - asynchronous active-low reset (count -> 0)
//               load     - load load_val on the next edge
//               load_val - value to load
//               dec      - decrement on the next edge
//               zero     - high while the count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module psdsqrt_cyc_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/psdsqrt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psdsqrt_seq_ctrl
// Description : Sequencer in front of the psdsqrt square-root unit. Accepts
//               an operand on a valid/ready port, issues the start pulse,
//               waits the datapath's cycle budget, issues the stop pulse,
//               captures the root and offers it on a valid/ready port.
// Ports       : clock, reset_n          - clock / async active-low reset
//               in_valid, in_ready, in_x - operand handshake
//               sqrt_xin, sqrt_start,
//               sqrt_stop, sqrt_res      - psdsqrt datapath interface
//               out_valid, out_ready,
//               out_sqrt                 - result handshake
//               busy                     - high in every state but IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module psdsqrt_seq_ctrl
    import psdsqrt_pkg::*;
#(
    parameter int NBITSIN = DEFAULT_NBITSIN,
    parameter int K       = DEFAULT_K
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBITSIN-1:0]     in_x,
    output logic [NBITSIN-1:0]     sqrt_xin,
    output logic                   sqrt_start,
    output logic                   sqrt_stop,
    input  logic [NBITSIN/2-1:0]   sqrt_res,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NBITSIN/2-1:0]   out_sqrt,
    output logic                   busy
);

    localparam int                   NCYCLES   = ncycles(NBITSIN, K);
    localparam int                   CNT_WIDTH = cnt_width(NCYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD  = CNT_WIDTH'(NCYCLES - 1);

    // psdsqrt only produces a well-formed root for even widths.
    generate
        if (((NBITSIN % 2) != 0) || (((NBITSIN + K) % 2) != 0)) begin : g_bad_params
            $error("psdsqrt_seq_ctrl: NBITSIN and NBITSIN+K must both be even");
        end
    endgenerate

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_in_ready;
    logic [NBITSIN-1:0]     r_xin;
    logic [NBITSIN/2-1:0]   r_root;
    logic                   w_accept;
    logic                   w_cnt_load;
    logic                   w_cnt_dec;
    logic                   w_cnt_zero;

    assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_ready;

    psdsqrt_cyc_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cyc_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (w_cnt_load),
        .load_val (CNT_LOAD),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    // Next-state decode. WAIT is entered with NCYCLES-1 in the counter and
    // left in the cycle the counter reads zero, giving exactly NCYCLES
    // WAIT cycles.
    always_comb begin
        w_next_state = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                w_cnt_load   = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_STOP;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_STOP: begin
                w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // in_ready is registered from the next state so that it is low during
    // reset and first reads high one edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_xin      <= '0;
            r_root     <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == ST_IDLE);
            if (w_accept) begin
                r_xin <= in_x;
            end
            if (r_state == ST_CAPTURE) begin
                r_root <= sqrt_res;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign sqrt_xin   = r_xin;
    assign out_sqrt   = r_root;
    assign sqrt_start = (r_state == ST_START);
    assign sqrt_stop  = (r_state == ST_STOP);
    assign out_valid  = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_psdsqrt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_psdsqrt_seq_ctrl
// Description : Self-checking bench for psdsqrt_seq_ctrl at the default
//               geometry (32/8) and at 16/4. A behavioural psdsqrt stand-in
//               only presents the true root after it has seen the stop pulse,
//               so an early capture returns a wrong value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psdsqrt_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sel;          // 0: 32-bit instance, 1: 16-bit instance
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_x;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // ---------------- 32/8 instance ----------------
    logic        a_in_valid, a_out_ready, a_in_ready;
    logic        a_sqrt_start, a_sqrt_stop, a_out_valid, a_busy;
    logic [31:0] a_sqrt_xin, a_lat;
    logic [15:0] a_sqrt_res, a_out_sqrt;

    assign a_in_valid  = in_valid & ~sel;
    assign a_out_ready = out_ready & ~sel;

    psdsqrt_seq_ctrl #(.NBITSIN(32), .K(8)) u_dut_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_x       (in_x),
        .sqrt_xin   (a_sqrt_xin),
        .sqrt_start (a_sqrt_start),
        .sqrt_stop  (a_sqrt_stop),
        .sqrt_res   (a_sqrt_res),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_sqrt   (a_out_sqrt),
        .busy       (a_busy)
    );

    // ---------------- 16/4 instance ----------------
    logic        b_in_valid, b_out_ready, b_in_ready;
    logic        b_sqrt_start, b_sqrt_stop, b_out_valid, b_busy;
    logic [15:0] b_in_x, b_sqrt_xin, b_lat;
    logic [7:0]  b_sqrt_res, b_out_sqrt;

    assign b_in_valid  = in_valid & sel;
    assign b_out_ready = out_ready & sel;
    assign b_in_x      = in_x[15:0];

    psdsqrt_seq_ctrl #(.NBITSIN(16), .K(4)) u_dut_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_x       (b_in_x),
        .sqrt_xin   (b_sqrt_xin),
        .sqrt_start (b_sqrt_start),
        .sqrt_stop  (b_sqrt_stop),
        .sqrt_res   (b_sqrt_res),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_sqrt   (b_out_sqrt),
        .busy       (b_busy)
    );

    // ---------------- selected-instance view ----------------
    logic        cur_in_ready, cur_sqrt_start, cur_sqrt_stop, cur_out_valid, cur_busy;
    logic [31:0] cur_sqrt_xin;
    logic [15:0] cur_out_sqrt;

    assign cur_in_ready   = sel ? b_in_ready   : a_in_ready;
    assign cur_sqrt_start = sel ? b_sqrt_start : a_sqrt_start;
    assign cur_sqrt_stop  = sel ? b_sqrt_stop  : a_sqrt_stop;
    assign cur_out_valid  = sel ? b_out_valid  : a_out_valid;
    assign cur_busy       = sel ? b_busy       : a_busy;
    assign cur_sqrt_xin   = sel ? {16'd0, b_sqrt_xin} : a_sqrt_xin;
    assign cur_out_sqrt   = sel ? {8'd0, b_out_sqrt}  : a_out_sqrt;

    // Golden integer square root (largest r with r*r <= x).
    function automatic logic [31:0] isqrt(input logic [63:0] x);
        logic [31:0] r;
        logic [31:0] c;
        r = 32'd0;
        for (int b = 15; b >= 0; b--) begin
            c = r | (32'd1 << b);
            if ((64'(c) * 64'(c)) <= x) r = c;
        end
        return r;
    endfunction

    // Wait-cycle budget of the selected instance.
    function automatic int nc_cur();
        return sel ? (16 + 4) / 2 : (32 + 8) / 2;
    endfunction

    // Behavioural psdsqrt units: a wrong value until stop is seen.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_lat      <= 32'd0;
            a_sqrt_res <= 16'd0;
        end else begin
            if (a_sqrt_start) begin
                a_lat      <= a_sqrt_xin;
                a_sqrt_res <= ~16'(isqrt(64'(a_sqrt_xin)));
            end
            if (a_sqrt_stop) a_sqrt_res <= 16'(isqrt(64'(a_lat)));
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            b_lat      <= 16'd0;
            b_sqrt_res <= 8'd0;
        end else begin
            if (b_sqrt_start) begin
                b_lat      <= b_sqrt_xin;
                b_sqrt_res <= ~8'(isqrt(64'(b_sqrt_xin)));
            end
            if (b_sqrt_stop) b_sqrt_res <= 8'(isqrt(64'(b_lat)));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Follows one operation from just after its accept edge E0 through the
    // output handshake. Sample index i is the interval between Ei and Ei+1.
    task automatic track_op(input logic [31:0] x, input int stall);
        int          nc;
        int          start_cnt, start_pos, stop_cnt, stop_pos, ov_pos;
        bit          ready_low, busy_hi, stable;
        logic [31:0] exp_root;
        logic [15:0] held;
        nc        = nc_cur();
        exp_root  = isqrt(64'(x));
        start_cnt = 0; start_pos = -1;
        stop_cnt  = 0; stop_pos  = -1;
        ov_pos    = -1;
        ready_low = 1'b1;
        busy_hi   = 1'b1;
        for (int i = 0; i < nc + 12; i++) begin
            @(negedge clock);
            if (cur_sqrt_start) begin start_cnt++; start_pos = i; end
            if (cur_sqrt_stop)  begin stop_cnt++;  stop_pos  = i; end
            if (cur_in_ready) ready_low = 1'b0;
            if (!cur_busy)    busy_hi   = 1'b0;
            if (cur_out_valid) begin ov_pos = i; break; end
        end
        chk("start_count", 64'(start_cnt), 64'd1);
        chk("start_pos",   64'(start_pos), 64'd0);
        chk("stop_count",  64'(stop_cnt),  64'd1);
        chk("stop_pos",    64'(stop_pos),  64'(nc + 1));
        chk("valid_pos",   64'(ov_pos),    64'(nc + 3));
        chk("out_sqrt",    64'(cur_out_sqrt), 64'(exp_root));
        chk("sqrt_xin",    64'(cur_sqrt_xin), 64'(x));
        chk("ready_low_busy", 64'(ready_low), 64'd1);
        chk("busy_high",   64'(busy_hi),   64'd1);
        held   = cur_out_sqrt;
        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            if (!(cur_out_valid && !cur_in_ready && (cur_out_sqrt == held))) stable = 1'b0;
        end
        if (stall > 0) chk("stall_hold", 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
    endtask

    // Offers x; optionally keeps in_valid high with injx for the whole
    // operation to check that it is neither consumed nor latched early.
    task automatic do_op(input logic [31:0] x_in, input int stall,
                         input bit inject, input logic [31:0] injx_in);
        logic [31:0] x, injx;
        x    = sel ? (x_in & 32'h0000_FFFF)    : x_in;
        injx = sel ? (injx_in & 32'h0000_FFFF) : injx_in;
        @(negedge clock);
        in_x     = x;
        in_valid = 1'b1;
        for (int t = 0; t < 60 && !cur_in_ready; t++) @(negedge clock);
        chk("accept_ready", 64'(cur_in_ready), 64'd1);
        @(posedge clock);
        #1;
        if (inject) in_x = injx;
        else        in_valid = 1'b0;
        track_op(x, stall);
        if (inject) begin
            @(negedge clock);
            chk("inj_idle_busy",  64'(cur_busy),     64'd0);
            chk("inj_idle_ready", 64'(cur_in_ready), 64'd1);
            chk("inj_xin_kept",   64'(cur_sqrt_xin), 64'(x));
            @(posedge clock);
            #1 in_valid = 1'b0;
            track_op(injx, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen_bad;
        logic [31:0] rx;

        reset_n   = 1'b0;
        sel       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = 32'd0;

        // ---- reset then idle ----
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready",  64'(a_in_ready),  64'd0);
        chk("rst_busy",      64'(a_busy),      64'd0);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_start_stop", 64'({a_sqrt_start, a_sqrt_stop}), 64'd0);
        chk("rst_sqrt_xin",  64'(a_sqrt_xin),  64'd0);
        chk("rst_out_sqrt",  64'(a_out_sqrt),  64'd0);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd0);
        reset_n = 1'b1;
        #1 chk("rel_in_ready_before_edge", 64'(a_in_ready), 64'd0);
        @(posedge clock);
        #1 chk("rel_in_ready_after_edge", 64'(a_in_ready), 64'd1);
        seen_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (a_sqrt_start || a_sqrt_stop || a_busy || a_out_valid) seen_bad = 1'b1;
        end
        chk("idle_quiet", 64'(seen_bad), 64'd0);

        // ---- single op and sequence with stall ----
        do_op(32'd123456, 0, 1'b0, 32'd0);
        do_op(32'd543210, 0, 1'b0, 32'd0);
        do_op(32'd12,     0, 1'b0, 32'd0);
        do_op(32'd1057,   5, 1'b0, 32'd0);
        do_op(32'd0,      0, 1'b0, 32'd0);
        do_op(32'hFFFF_FFFF, 0, 1'b0, 32'd0);

        // ---- in_valid held through WAIT and DONE with another operand ----
        do_op(32'd1000, 2, 1'b1, 32'd2500);

        // ---- reset mid-WAIT ----
        @(negedge clock);
        in_x     = 32'd777;
        in_valid = 1'b1;
        for (int t = 0; t < 60 && !a_in_ready; t++) @(negedge clock);
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy",      64'(a_busy),      64'd0);
        chk("mid_rst_in_ready",  64'(a_in_ready),  64'd0);
        chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_stop",      64'(a_sqrt_stop), 64'd0);
        chk("mid_rst_sqrt_xin",  64'(a_sqrt_xin),  64'd0);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1 chk("mid_rst_ready_after_edge", 64'(a_in_ready), 64'd1);
        seen_bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (a_sqrt_stop || a_out_valid || a_busy) seen_bad = 1'b1;
        end
        chk("mid_rst_no_stop", 64'(seen_bad), 64'd0);
        do_op(32'd4291, 0, 1'b0, 32'd0);

        // ---- random operands on the default geometry ----
        for (int n = 0; n < 6; n++) begin
            rx = $urandom();
            do_op(rx, int'($urandom_range(0, 3)), 1'b0, 32'd0);
        end

        // ---- 16/4 geometry ----
        sel = 1'b1;
        do_op(32'd0,     0, 1'b0, 32'd0);
        do_op(32'd255,   0, 1'b0, 32'd0);
        do_op(32'd65535, 1, 1'b0, 32'd0);
        for (int n = 0; n < 4; n++) begin
            rx = $urandom();
            do_op(rx, int'($urandom_range(0, 3)), 1'b0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
